comparator_scheduler: RTL and testbench

COMPARATOR_SCHEDULER -- requirements
Module: comparator_scheduler

---
 rtl/comparator_scheduler_pkg.sv | 14 +
 rtl/comparator_scheduler_cmp.sv | 17 +
 rtl/comparator_scheduler.sv | 132 +++++++++++++
 tb/tb_comparator_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_scheduler_pkg.sv
// Shared types and defaults for the comparator scheduler.
// FSM state encoding plus default operand width and requester count.
package comparator_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam int DEF_W     = 4;
    localparam int DEF_N_REQ = 4;

endpackage

// File: rtl/comparator_scheduler_cmp.sv
// Unsigned magnitude comparator; purely combinational, zero latency.
// No flow control: outputs follow a/b directly.
module FourBitComparator #(
    parameter int W = 4
) (
    output logic         g,
    output logic         e,
    output logic         l,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b
);

    assign g = (a > b);
    assign e = (a == b);
    assign l = (a < b);

endmodule

// File: rtl/comparator_scheduler.sv
// Round-robin scheduler sharing one comparator; optional CMP_SCHED_STATS_EN adds stat_count.
// Latency: grant at edge N, registered result valid after edge N+1; one result per 3 cycles.
// Backpressure: result held while rsp_ready low; no new grant until the response is taken.
module comparator_scheduler
    import comparator_scheduler_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*W-1:0]       req_a,
    input  logic [N_REQ*W-1:0]       req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic                     rsp_g,
    output logic                     rsp_e,
    output logic                     rsp_l
`ifdef CMP_SCHED_STATS_EN
    ,
    output logic [15:0]              stat_count
`endif
);

    localparam int IW = $clog2(N_REQ);

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   win;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    win_a;
    logic [W-1:0]    win_b;
    logic            any_req;
    logic            accept;
    logic            rsp_fire;
    logic            cmp_g;
    logic            cmp_e;
    logic            cmp_l;

    // Scan downward so the requester closest to p (ascending, wrapping) is the last to overwrite.
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] v, input logic [IW-1:0] p);
        logic [IW-1:0] pick;
        int            idx;
        pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % N_REQ;
            if (v[idx]) pick = idx[IW-1:0];
        end
        return pick;
    endfunction

    assign any_req  = |req_valid;
    assign win      = rr_pick(req_valid, ptr_q);
    assign win_a    = req_a[win*W +: W];
    assign win_b    = req_b[win*W +: W];
    // Grant is suppressed during reset so no requester sees a handshake that gets discarded.
    assign accept   = (state_q == IDLE) && any_req && !rst;
    assign rsp_fire = (state_q == RESPOND) && rsp_ready;

    FourBitComparator #(.W(W)) u_cmp (
        .g (cmp_g),
        .e (cmp_e),
        .l (cmp_l),
        .a (a_q),
        .b (b_q)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req)   state_d = COMPARE;
            COMPARE:                state_d = RESPOND;
            RESPOND: if (rsp_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
            rsp_g     <= 1'b0;
            rsp_e     <= 1'b0;
            rsp_l     <= 1'b0;
        end else begin
            if (accept) begin
                a_q    <= win_a;
                b_q    <= win_b;
                rsp_id <= win;
            end
            if (state_q == COMPARE) begin
                rsp_valid <= 1'b1;
                rsp_g     <= cmp_g;
                rsp_e     <= cmp_e;
                rsp_l     <= cmp_l;
            end
            if (rsp_fire) begin
                rsp_valid <= 1'b0;
                rsp_g     <= 1'b0;
                rsp_e     <= 1'b0;
                rsp_l     <= 1'b0;
                ptr_q     <= (rsp_id == IW'(N_REQ - 1)) ? '0 : rsp_id + 1'b1;
            end
        end
    end

`ifdef CMP_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)           stat_count <= 16'd0;
        else if (rsp_fire) stat_count <= stat_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_comparator_scheduler.sv
// Directed and randomized checks of comparator_scheduler against a transaction-level model.
module tb_comparator_scheduler;

    localparam int NR = 4;
    localparam int WD = 4;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*WD-1:0] req_a;
    logic [NR*WD-1:0] req_b;
    logic [NR-1:0]    req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic             rsp_g;
    logic             rsp_e;
    logic             rsp_l;
`ifdef CMP_SCHED_STATS_EN
    logic [15:0]      stat_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int ptr_m  = 0;
    int stat_m = 0;

    comparator_scheduler #(.N_REQ(NR), .W(WD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_g     (rsp_g),
        .rsp_e     (rsp_e),
        .rsp_l     (rsp_l)
`ifdef CMP_SCHED_STATS_EN
        ,
        .stat_count(stat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: first valid requester at or after the pointer, wrapping.
    function automatic int model_pick(input logic [NR-1:0] v);
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (ptr_m + k) % NR;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_stats();
`ifdef CMP_SCHED_STATS_EN
        check("stat_count", 32'(stat_count), 32'(stat_m));
`endif
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'(($urandom) & 1);
        step();
        check("rst_no_grant", 32'(req_ready), 32'd0);
        step();
        check("rst_rdy", 32'(req_ready), 32'd0);
        check("rst_vld", 32'(rsp_valid), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_gel", 32'({rsp_g, rsp_e, rsp_l}), 32'd0);
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        ptr_m     = 0;
        stat_m    = 0;
        check_stats();
    endtask

    // One full transaction from IDLE; bp = cycles of rsp_ready low while in RESPOND.
    task automatic txn(input logic [NR-1:0] v, input logic [NR*WD-1:0] a,
                       input logic [NR*WD-1:0] b, input int bp);
        int            w;
        logic [WD-1:0] ea;
        logic [WD-1:0] eb;
        logic [2:0]    gel;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = 1'b0;
        #1;
        w = model_pick(v);
        if (w < 0) begin
            check("idle_no_grant", 32'(req_ready), 32'd0);
            step();
            check("idle_no_rsp", 32'(rsp_valid), 32'd0);
        end else begin
            ea  = a[w*WD +: WD];
            eb  = b[w*WD +: WD];
            gel = {ea > eb, ea == eb, ea < eb};
            check("grant", 32'(req_ready), 32'd1 << w);
            step();
            req_valid = NR'($urandom);
            req_a     = (NR*WD)'($urandom);
            req_b     = (NR*WD)'($urandom);
            #1;
            check("cmp_rdy", 32'(req_ready), 32'd0);
            check("cmp_vld", 32'(rsp_valid), 32'd0);
            step();
            check("rsp_vld", 32'(rsp_valid), 32'd1);
            check("rsp_id", 32'(rsp_id), 32'(w));
            check("rsp_gel", 32'({rsp_g, rsp_e, rsp_l}), 32'(gel));
            check("rsp_rdy", 32'(req_ready), 32'd0);
            for (int k = 0; k < bp; k++) begin
                step();
                req_valid = NR'($urandom);
                #1;
                check("bp_vld", 32'(rsp_valid), 32'd1);
                check("bp_id", 32'(rsp_id), 32'(w));
                check("bp_gel", 32'({rsp_g, rsp_e, rsp_l}), 32'(gel));
                check("bp_rdy", 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
            req_valid = '0;
            step();
            rsp_ready = 1'b0;
            check("done_vld", 32'(rsp_valid), 32'd0);
            check("done_gel", 32'({rsp_g, rsp_e, rsp_l}), 32'd0);
            ptr_m  = (w + 1) % NR;
            stat_m = (stat_m + 1) % 65536;
            check_stats();
        end
    endtask

    initial begin
        logic [NR*WD-1:0] ra;
        logic [NR*WD-1:0] rb;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        do_reset();

        // Single request: a0=0 < b0=8.
        txn(4'b0001, 16'h0000, 16'h0008, 0);

        // All valid, responses taken at once: grants 0,1,2,3,0 with g,e,l,g,g.
        do_reset();
        for (int i = 0; i < 5; i++)
            txn(4'b1111, {4'b0100, 4'b0000, 4'b1010, 4'b1000},
                         {4'b0010, 4'b0001, 4'b1010, 4'b0000}, 0);

        // Backpressure for five cycles.
        txn(4'b0110, 16'h3C51, 16'h3C15, 5);

        // Wrap-around: serve id 2, then 3 before 0.
        txn(4'b0100, 16'h0700, 16'h0300, 0);
        txn(4'b1001, 16'h2001, 16'h2005, 1);
        txn(4'b1001, 16'h2001, 16'h2005, 0);

        // Reset while in COMPARE discards the transaction.
        req_valid = 4'b0010;
        req_a     = 16'h0050;
        req_b     = 16'h0020;
        #1;
        check("pre_rst_grant", 32'(req_ready), 32'b0010);
        step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        check("rstc_vld", 32'(rsp_valid), 32'd0);
        check("rstc_gel", 32'({rsp_g, rsp_e, rsp_l}), 32'd0);
        step();
        check("rstc_vld2", 32'(rsp_valid), 32'd0);
        ptr_m  = 0;
        stat_m = 0;
        check_stats();
        txn(4'b0010, 16'h0050, 16'h0020, 0);

        // Reset in RESPOND beats a concurrent response handshake.
        req_valid = 4'b0100;
        req_a     = 16'h0900;
        req_b     = 16'h0100;
        step();
        req_valid = '0;
        step();
        check("rstr_vld_before", 32'(rsp_valid), 32'd1);
        rst       = 1'b1;
        rsp_ready = 1'b1;
        step();
        rst       = 1'b0;
        rsp_ready = 1'b0;
        #1;
        check("rstr_vld", 32'(rsp_valid), 32'd0);
        check("rstr_id", 32'(rsp_id), 32'd0);
        ptr_m  = 0;
        stat_m = 0;
        check_stats();
        txn(4'b1111, 16'h1234, 16'h4321, 0);

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            ra = (NR*WD)'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? ra : (NR*WD)'($urandom);
            txn(NR'($urandom), ra, rb, $urandom_range(0, 3));
        end

        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
